// File: rtl/bsa_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer.
package bsa_pkg;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bsa_state_t;

  localparam int BSA_MIN_WIDTH = 2;
  localparam int BSA_MAX_WIDTH = 32;

  // Bit-counter width. The counter only has to reach WIDTH-1, and it is kept
  // at least one bit wide.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage : bsa_pkg

// File: rtl/fa_bit.sv
// Single 1-bit full-adder cell, reused for every bit of a serial operation.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | ((a ^ b) & cin);

endmodule : fa_bit

// File: rtl/bit_serial_addsub.sv
// WIDTH-bit add/subtract that pushes one bit per cycle, LSB first, through a
// single full-adder cell. A start/done handshake frames each operation.
module bit_serial_addsub
  import bsa_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(WIDTH - 2);

  bsa_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sreg_a;
  logic [WIDTH-1:0] sreg_b;
  logic [WIDTH-1:0] sreg_r;
  logic             carry;
  logic             c_msb_in;

  logic             bit_s;
  logic             bit_co;
  logic             load;
  logic             running;
  logic             last_bit;

  // A new operation may only start from IDLE or DONE; start during RUN is ignored.
  assign load     = start && ((state == IDLE) || (state == DONE));
  assign running  = (state == RUN);
  assign last_bit = running && (cnt == CNT_LAST);

  fa_bit u_fa (
    .a    (sreg_a[0]),
    .b    (sreg_b[0]),
    .cin  (carry),
    .sum  (bit_s),
    .cout (bit_co)
  );

  // Control FSM: state, bit counter and the registered handshake/result outputs.
  // NOTE: every clocked assignment is non-blocking so all registers update from
  // the same pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (load) begin
            state <= RUN;
            cnt   <= '0;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (last_bit) begin
            // Final bit: publish the complete result and leave RUN.
            state    <= DONE;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
            sum      <= {bit_s, sreg_r[WIDTH-1:1]};
            cout     <= bit_co;
            overflow <= c_msb_in ^ bit_co;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Datapath: operand/result shift registers, carry flip-flop and MSB carry-in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_a   <= '0;
      sreg_b   <= '0;
      sreg_r   <= '0;
      carry    <= 1'b0;
      c_msb_in <= 1'b0;
    end else if (load) begin
      // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
      sreg_a <= a;
      sreg_b <= sub ? ~b : b;
      carry  <= sub;
    end else if (running) begin
      sreg_a <= {1'b0, sreg_a[WIDTH-1:1]};
      sreg_b <= {1'b0, sreg_b[WIDTH-1:1]};
      sreg_r <= {bit_s, sreg_r[WIDTH-1:1]};
      carry  <= bit_co;
      // The carry leaving bit WIDTH-2 is the carry into the MSB, needed for
      // signed overflow on the final cycle.
      if (cnt == CNT_PRE) begin
        c_msb_in <= bit_co;
      end
    end
  end

endmodule : bit_serial_addsub

// File: tb/tb_bit_serial_addsub.sv
// Self-checking bench for bit_serial_addsub (WIDTH=8): directed scenarios
// followed by randomized operations compared against an arithmetic model.
module tb_bit_serial_addsub;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  // Last result the model expects to be visible on the outputs.
  logic [W-1:0] exp_sum;
  logic         exp_cout;
  logic         exp_ovf;

  bit_serial_addsub #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something blocks forever.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: plain integer arithmetic. Returns {overflow, cout, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic s);
    int ux, uy, sx, sy, ures, sres;
    logic [W-1:0] r;
    logic c, v;
    ux = int'(x);
    uy = int'(y);
    sx = $signed(x);
    sy = $signed(y);
    if (s) begin
      ures = ux - uy;
      sres = sx - sy;
      c    = (ux >= uy);
    end else begin
      ures = ux + uy;
      sres = sx + sy;
      c    = (ures >= (1 << W));
    end
    r = ures[W-1:0];
    v = (sres > ((1 << (W-1)) - 1)) || (sres < -(1 << (W-1)));
    return {v, c, r};
  endfunction

  // Wait (bounded) for done. Samples #1 after each rising edge; counts the
  // cycles elapsed, busy cycles seen, and whether outputs held their old result.
  task automatic wait_done(input bit noise, output int cyc, output int busy_n,
                           output bit held);
    cyc    = 0;
    busy_n = 0;
    held   = 1'b1;
    while (!done && cyc < 20) begin
      if (busy) busy_n++;
      if (sum !== exp_sum || cout !== exp_cout || overflow !== exp_ovf) held = 1'b0;
      if (noise) begin
        start = 1'($urandom);
        a     = W'($urandom);
        b     = W'($urandom);
        sub   = 1'($urandom);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
  endtask

  // Launch one operation after 'gap' extra cycles and check timing and result.
  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic os,
                        input int gap, input bit noise, input string tag);
    int cyc, busy_n;
    bit held;
    logic [W+1:0] e;
    repeat (gap) @(posedge clk);
    @(negedge clk);
    a = oa; b = ob; sub = os; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    wait_done(noise, cyc, busy_n, held);
    e = model(oa, ob, os);
    check({tag, ".done"},    32'(done),     32'd1);
    check({tag, ".latency"}, 32'(cyc),      32'(W));
    check({tag, ".busy_n"},  32'(busy_n),   32'(W));
    check({tag, ".busy_lo"}, 32'(busy),     32'd0);
    check({tag, ".held"},    32'(held),     32'd1);
    check({tag, ".sum"},     32'(sum),      32'(e[W-1:0]));
    check({tag, ".cout"},    32'(cout),     32'(e[W]));
    check({tag, ".ovf"},     32'(overflow), 32'(e[W+1]));
    exp_sum  = e[W-1:0];
    exp_cout = e[W];
    exp_ovf  = e[W+1];
  endtask

  initial begin
    int cyc, busy_n;
    bit held;
    bit saw_done;
    logic [W-1:0] ra, rb;

    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    exp_sum = '0; exp_cout = 1'b0; exp_ovf = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.sum",  32'(sum),  32'd0);
    check("rst.cout", 32'(cout), 32'd0);
    check("rst.ovf",  32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed add/sub cases.
    run_op(8'h35, 8'h4A, 1'b0, 1, 1'b0, "add_35_4a");
    @(posedge clk);
    #1;
    check("done_single_pulse", 32'(done), 32'd0);
    check("done_hold_sum",     32'(sum),  32'h7F);
    run_op(8'hFF, 8'h01, 1'b0, 0, 1'b0, "add_ff_01");
    run_op(8'h7F, 8'h01, 1'b0, 2, 1'b0, "add_7f_01");
    run_op(8'h05, 8'h07, 1'b1, 0, 1'b0, "sub_05_07");
    run_op(8'h80, 8'h01, 1'b1, 1, 1'b0, "sub_80_01");

    // Start pulsed mid-RUN is ignored; then back-to-back start held in DONE.
    @(posedge clk);
    @(negedge clk);
    a = 8'h35; b = 8'h4A; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    a = 8'h11; b = 8'h00; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(1'b0, cyc, busy_n, held);
    check("ign.latency", 32'(cyc + 3), 32'(W));
    check("ign.sum",     32'(sum),     32'h7F);
    check("ign.cout",    32'(cout),    32'd0);
    exp_sum = 8'h7F; exp_cout = 1'b0; exp_ovf = 1'b0;
    a = 8'h01; b = 8'h02; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b.busy", 32'(busy), 32'd1);
    wait_done(1'b0, cyc, busy_n, held);
    check("b2b.spacing", 32'(cyc + 1), 32'(W + 1));
    check("b2b.held",    32'(held),    32'd1);
    check("b2b.sum",     32'(sum),     32'h03);
    exp_sum = 8'h03;

    // Reset asserted in cycle 4 of RUN aborts without a done pulse.
    @(posedge clk);
    @(negedge clk);
    a = 8'h44; b = 8'h22; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst.busy", 32'(busy), 32'd0);
    check("arst.done", 32'(done), 32'd0);
    check("arst.sum",  32'(sum),  32'd0);
    check("arst.cout", 32'(cout), 32'd0);
    check("arst.ovf",  32'(overflow), 32'd0);
    saw_done = 1'b0;
    repeat (W) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    check("arst.no_done", 32'(saw_done), 32'd0);
    exp_sum = '0; exp_cout = 1'b0; exp_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h10, 8'h20, 1'b0, 1, 1'b0, "post_rst_add");

    // Corner operands.
    run_op(8'h00, 8'h00, 1'b1, 0, 1'b0, "sub_00_00");
    run_op(8'h80, 8'h80, 1'b0, 0, 1'b0, "add_80_80");
    run_op(8'h7F, 8'hFF, 1'b1, 1, 1'b0, "sub_7f_ff");
    run_op(8'hFF, 8'hFF, 1'b0, 0, 1'b0, "add_ff_ff");

    // Randomized operations with random gaps and start/operand noise during RUN.
    for (int i = 0; i < 400; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_op(ra, rb, 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom),
             $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_bit_serial_addsub
